// File: rtl/fir_seq_mac_pkg.sv
// Shared definitions for the sequential-MAC FIR filter.
// Holds FSM states and the width helpers used by the top and MAC unit.
package fir_seq_mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Accumulator sized so that TAPS full-scale products never overflow.
  function automatic int acc_width(
    input int dw,
    input int cw,
    input int taps
  );
    return dw + cw + clog2(taps);
  endfunction

endpackage

// File: rtl/fir_seq_mac_mac_unit.sv
// Single shared multiplier, accumulator and output formatter.
// Formatter clamps or wraps the accumulator into the output width.
module fir_mac_unit
  import fir_seq_mac_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 18,
  parameter int OUT_W  = 16,
  parameter bit SIGNED = 1'b0,
  parameter bit SAT    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] x_i,
  input  logic [COEF_W-1:0] h_i,
  output logic [OUT_W-1:0]  fmt_o
);

  localparam int PW = DATA_W + COEF_W;
  localparam int EW = ACC_W - PW;

  logic [ACC_W-1:0] term;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

  if (SIGNED) begin : g_mul_s
    logic signed [PW-1:0] p;
    assign p = PW'($signed(x_i)) * PW'($signed(h_i));
    assign term = {{EW{p[PW-1]}}, p};
  end else begin : g_mul_u
    logic [PW-1:0] p;
    assign p = PW'(x_i) * PW'(h_i);
    assign term = {{EW{1'b0}}, p};
  end

  // Next accumulator: clear on sample accept, add one product per MAC cycle.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + term;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  if (ACC_W <= OUT_W) begin : g_fmt_ext
    if (SIGNED) begin : g_s
      assign fmt_o = OUT_W'($signed(acc_q));
    end else begin : g_u
      assign fmt_o = OUT_W'(acc_q);
    end
  end else if (!SAT) begin : g_fmt_wrap
    assign fmt_o = acc_q[OUT_W-1:0];
  end else if (SIGNED) begin : g_fmt_sat_s
    logic [ACC_W-OUT_W:0] top;
    logic fits;
    assign top  = acc_q[ACC_W-1:OUT_W-1];
    assign fits = (&top) | ~(|top);
    // Clamp to the signed output range when the top bits disagree.
    always_comb begin
      fmt_o = acc_q[OUT_W-1:0];
      if (!fits) begin
        fmt_o = acc_q[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                               : {1'b0, {(OUT_W-1){1'b1}}};
      end
    end
  end else begin : g_fmt_sat_u
    logic [ACC_W-OUT_W-1:0] hi;
    assign hi = acc_q[ACC_W-1:OUT_W];
    // Clamp to all-ones when any bit above the output width is set.
    always_comb begin
      fmt_o = acc_q[OUT_W-1:0];
      if (|hi) begin
        fmt_o = '1;
      end
    end
  end

endmodule

// File: rtl/fir_seq_mac.sv
// Sequential FIR: one sample per go, one multiply per cycle over TAPS taps.
// Holds the delay line, coefficient file, control FSM and tap index.
module fir_seq_mac
  import fir_seq_mac_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 4,
  parameter int OUT_W  = 16,
  parameter bit SIGNED = 1'b0,
  parameter bit SAT    = 1'b1,
  localparam int AW    = clog2(TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in,
  input  logic              go,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic [OUT_W-1:0]  y,
  output logic              done,
  output logic              busy
);

  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);

  logic [DATA_W-1:0] x_q [TAPS];
  logic [COEF_W-1:0] h_q [TAPS];
  state_e            state_q;
  logic [AW-1:0]     idx_q;
  logic [OUT_W-1:0]  y_q;
  logic              done_q;
  logic [OUT_W-1:0]  fmt;
  logic              idle;
  logic              accept;
  logic              last;
  logic              coef_ok;

  assign idle    = (state_q == ST_IDLE);
  assign accept  = idle & go;
  assign last    = (idx_q == AW'(TAPS - 1));
  assign coef_ok = (int'(coef_addr) < TAPS);

  // Delay line shifts only when a sample is accepted in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
    end else if (accept) begin
      x_q[0] <= in;
      for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
    end
  end

  // Coefficients are writable only while idle so MAC sees stable taps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) h_q[k] <= COEF_W'(1);
    end else if (idle && coef_we && coef_ok) begin
      h_q[coef_addr] <= coef_data;
    end
  end

  // Control FSM: IDLE -> MAC (TAPS cycles) -> OUT -> IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (go) begin
            idx_q   <= '0;
            state_q <= ST_MAC;
          end
        end
        ST_MAC: begin
          idx_q <= idx_q + 1'b1;
          if (last) state_q <= ST_OUT;
        end
        ST_OUT: begin
          y_q     <= fmt;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  fir_mac_unit #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W),
    .OUT_W  (OUT_W),
    .SIGNED (SIGNED),
    .SAT    (SAT)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept),
    .en_i  (state_q == ST_MAC),
    .x_i   (x_q[idx_q]),
    .h_i   (h_q[idx_q]),
    .fmt_o (fmt)
  );

  assign y    = y_q;
  assign done = done_q;
  assign busy = ~idle;

endmodule
